xbus_ram_ws: RTL and testbench



---
 rtl/xbus_pkg.sv | 22 ++
 rtl/xbus_ram_array.sv | 49 ++++
 rtl/xbus_ram_ws.sv | 151 +++++++++++++++
 tb/tb_xbus_ram_ws.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/xbus_pkg.sv
// ---------------------------------------------------------------------------
// xbus_pkg
// Shared xbus definitions: bus address width, byte width, the RAM slave FSM
// state encoding and a helper for the out-of-range address check.
// ---------------------------------------------------------------------------
package xbus_pkg;

  localparam int XBUS_AW = 32;
  localparam int BYTEW   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } xbus_state_e;

  // An address is out of range when any bit above the decoded word index is set.
  function automatic logic addr_oor(input logic [XBUS_AW-1:0] addr, input int unsigned lo);
    return ((addr >> lo) != 32'd0);
  endfunction

endpackage

// File: rtl/xbus_ram_array.sv
// ---------------------------------------------------------------------------
// xbus_ram_array
// Single-port synchronous RAM with per-byte write enables, coded so that it
// maps onto block RAM with byte-write enables.
// Ports:
//   clk    in   clock
//   en     in   access enable
//   we     in   1 = write, 0 = read
//   be     in   byte-lane write enables (DATA_W/8)
//   addr   in   word address (ADDR_W)
//   wdata  in   write data (DATA_W)
//   rdata  out  registered read data; updated only by read accesses
// ---------------------------------------------------------------------------
module xbus_ram_array
  import xbus_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_W/BYTEW-1:0] be,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  localparam int NB = DATA_W / BYTEW;

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // Byte-lane writes; the output register only moves on reads so it holds across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            r_mem[addr][i*BYTEW +: BYTEW] <= wdata[i*BYTEW +: BYTEW];
          end
        end
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule

// File: rtl/xbus_ram_ws.sv
// ---------------------------------------------------------------------------
// xbus_ram_ws
// Parametrised xbus RAM slave with configurable wait states and a registered
// ready/error handshake. Out-of-range accesses complete with xbus_err and do
// not touch memory.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   xbus_cs     in   request valid, held until xbus_ready is seen
//   xbus_we     in   1 = write, 0 = read
//   xbus_be     in   byte enables (DATA_W/8)
//   xbus_addr   in   byte address (32)
//   xbus_wdata  in   write data (DATA_W)
//   xbus_rdata  out  read data, valid with xbus_ready on reads
//   xbus_ready  out  one-cycle completion pulse
//   xbus_err    out  out-of-range flag, valid with xbus_ready
// ---------------------------------------------------------------------------
module xbus_ram_ws
  import xbus_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter int    DATA_W    = 32,
  parameter int    WAIT      = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    xbus_cs,
  input  logic                    xbus_we,
  input  logic [DATA_W/BYTEW-1:0] xbus_be,
  input  logic [XBUS_AW-1:0]      xbus_addr,
  input  logic [DATA_W-1:0]       xbus_wdata,
  output logic [DATA_W-1:0]       xbus_rdata,
  output logic                    xbus_ready,
  output logic                    xbus_err
);

  localparam int         NB        = DATA_W / BYTEW;
  localparam int         LSB       = $clog2(NB);
  localparam bit         ZERO_WAIT = (WAIT == 0);
  localparam logic [3:0] CNT_LOAD  = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  xbus_state_e       r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [NB-1:0]     r_be;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_oor;
  logic              r_ready;
  logic              r_err;
  logic              r_rd_valid;

  logic              w_oor;
  logic [ADDR_W-1:0] w_idx;
  logic              w_enter_resp;
  logic              w_acc_we;
  logic [NB-1:0]     w_acc_be;
  logic [ADDR_W-1:0] w_acc_idx;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_acc_oor;
  logic              w_ram_en;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_oor = addr_oor(xbus_addr, ADDR_W + LSB);
  assign w_idx = xbus_addr[ADDR_W+LSB-1:LSB];

  // With no wait states the accepting edge is also the RESP-entry edge, so the
  // array is fed from the bus (held stable by the master) rather than from the
  // request registers, which are being loaded on that same edge.
  assign w_enter_resp = ZERO_WAIT ? ((r_state == ST_IDLE) && xbus_cs)
                                  : ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_acc_we    = ZERO_WAIT ? xbus_we    : r_we;
  assign w_acc_be    = ZERO_WAIT ? xbus_be    : r_be;
  assign w_acc_idx   = ZERO_WAIT ? w_idx      : r_idx;
  assign w_acc_wdata = ZERO_WAIT ? xbus_wdata : r_wdata;
  assign w_acc_oor   = ZERO_WAIT ? w_oor      : r_oor;

  // Out-of-range accesses never reach the array.
  assign w_ram_en = w_enter_resp && !w_acc_oor;

  xbus_ram_array #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_acc_we),
    .be    (w_acc_be),
    .addr  (w_acc_idx),
    .wdata (w_acc_wdata),
    .rdata (w_ram_rdata)
  );

  // The array's output register cannot be reset; r_rd_valid masks it to zero
  // after reset and after an out-of-range read.
  assign xbus_rdata = r_rd_valid ? w_ram_rdata : {DATA_W{1'b0}};
  assign xbus_ready = r_ready;
  assign xbus_err   = r_err;

  // Request FSM, wait counter, request capture and registered handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_be       <= {NB{1'b0}};
      r_idx      <= {ADDR_W{1'b0}};
      r_wdata    <= {DATA_W{1'b0}};
      r_oor      <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      if (w_enter_resp) begin
        r_ready <= 1'b1;
        r_err   <= w_acc_oor;
        if (!w_acc_we) begin
          r_rd_valid <= !w_acc_oor;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (xbus_cs) begin
            r_we    <= xbus_we;
            r_be    <= xbus_be;
            r_idx   <= w_idx;
            r_wdata <= xbus_wdata;
            r_oor   <= w_oor;
            r_cnt   <= CNT_LOAD;
            r_state <= ZERO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // xbus_cs still belongs to the completing request here.
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_ram_ws.sv
// ---------------------------------------------------------------------------
// tb_xbus_ram_ws
// Three instances: A (32-bit, ADDR_W=12, WAIT=0), B (32-bit, ADDR_W=12,
// WAIT=3), C (64-bit, ADDR_W=4, WAIT=0). Requests push expected responses
// into per-instance queues; a monitor pops and compares on every xbus_ready.
// ---------------------------------------------------------------------------
module tb_xbus_ram_ws;

  localparam int W_A = 0;
  localparam int W_B = 3;
  localparam int W_C = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b, rst_n_c;
  logic        cs    [3];
  logic        we    [3];
  logic [7:0]  be    [3];
  logic [31:0] addr  [3];
  logic [63:0] wdata [3];
  logic        ready [3];
  logic        err   [3];
  logic [63:0] rd    [3];
  logic [31:0] rdata_a, rdata_b;
  logic [63:0] rdata_c;

  assign rd[0] = {32'd0, rdata_a};
  assign rd[1] = {32'd0, rdata_b};
  assign rd[2] = rdata_c;

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        is_read;
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  xbus_ram_ws #(.ADDR_W(12), .DATA_W(32), .WAIT(W_A), .INIT_FILE("")) u_a (
    .clk(clk), .rst_n(rst_n_a), .xbus_cs(cs[0]), .xbus_we(we[0]), .xbus_be(be[0][3:0]),
    .xbus_addr(addr[0]), .xbus_wdata(wdata[0][31:0]), .xbus_rdata(rdata_a),
    .xbus_ready(ready[0]), .xbus_err(err[0]));

  xbus_ram_ws #(.ADDR_W(12), .DATA_W(32), .WAIT(W_B), .INIT_FILE("")) u_b (
    .clk(clk), .rst_n(rst_n_b), .xbus_cs(cs[1]), .xbus_we(we[1]), .xbus_be(be[1][3:0]),
    .xbus_addr(addr[1]), .xbus_wdata(wdata[1][31:0]), .xbus_rdata(rdata_b),
    .xbus_ready(ready[1]), .xbus_err(err[1]));

  xbus_ram_ws #(.ADDR_W(4), .DATA_W(64), .WAIT(W_C), .INIT_FILE("")) u_c (
    .clk(clk), .rst_n(rst_n_c), .xbus_cs(cs[2]), .xbus_we(we[2]), .xbus_be(be[2]),
    .xbus_addr(addr[2]), .xbus_wdata(wdata[2]), .xbus_rdata(rdata_c),
    .xbus_ready(ready[2]), .xbus_err(err[2]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? W_A : ((d == 1) ? W_B : W_C);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request at an IDLE-cycle negedge, hold it until ready, keep cs
  // held through the RESP cycle, then release it in the following IDLE cycle.
  task automatic req(input int d, input logic w, input logic [7:0] b, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n;
    e.is_read = !w;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.due     = cyc + 1 + wait_of(d);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    cs[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    n = 0;
    @(negedge clk);
    while (ready[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_seen_dut%0d_addr%h", d, a), 64'(ready[d]), 64'd1);
    @(negedge clk);
    cs[d] = 1'b0;
  endtask

  // Scoreboard monitor: every ready pulse must match a queued expectation.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    for (int d = 0; d < 3; d++) begin
      if (ready[d] === 1'b1) begin
        have = 1'b0;
        case (d)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        chk($sformatf("ready_expected_dut%0d", d), 64'(have), 64'd1);
        if (have) begin
          chk($sformatf("resp_cycle_dut%0d", d), 64'(cyc), 64'(e.due));
          chk($sformatf("err_dut%0d", d), 64'(err[d]), 64'(e.err));
          if (e.is_read) begin
            chk($sformatf("rdata_dut%0d", d), rd[d], e.rdata);
          end
        end
      end
    end
  end

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cs[d] = 1'b0; we[d] = 1'b0; be[d] = 8'd0; addr[d] = 32'd0; wdata[d] = 64'd0;
    end
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ready_dut%0d", d), 64'(ready[d]), 64'd0);
      chk($sformatf("reset_err_dut%0d", d), 64'(err[d]), 64'd0);
      chk($sformatf("reset_rdata_dut%0d", d), rd[d], 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    @(negedge clk);

    // A: basic write/read, be=0, low address bits, byte lanes, range checks
    req(0, 1'b1, 8'hF, 32'h10,   64'hDEADBEEF, 64'd0,         1'b0);
    req(0, 1'b0, 8'hF, 32'h10,   64'd0,        64'hDEADBEEF,  1'b0);
    req(0, 1'b1, 8'h0, 32'h10,   64'hFFFFFFFF, 64'd0,         1'b0);
    chk("rdata_hold_after_write", rd[0], 64'hDEADBEEF);
    req(0, 1'b0, 8'hF, 32'h13,   64'd0,        64'hDEADBEEF,  1'b0);
    req(0, 1'b1, 8'hF, 32'h20,   64'h11223344, 64'd0,         1'b0);
    req(0, 1'b1, 8'h5, 32'h20,   64'hAABBCCDD, 64'd0,         1'b0);
    req(0, 1'b0, 8'hF, 32'h20,   64'd0,        64'h11BB33DD,  1'b0);
    req(0, 1'b1, 8'hF, 32'h0,    64'h00000A5A, 64'd0,         1'b0);
    req(0, 1'b1, 8'hF, 32'h4000, 64'h55,       64'd0,         1'b1);
    req(0, 1'b0, 8'hF, 32'h4000, 64'd0,        64'd0,         1'b1);
    req(0, 1'b0, 8'hF, 32'h0,    64'd0,        64'h00000A5A,  1'b0);
    req(0, 1'b1, 8'hF, 32'h3FFC, 64'h600DF00D, 64'd0,         1'b0);
    req(0, 1'b0, 8'hF, 32'h3FFC, 64'd0,        64'h600DF00D,  1'b0);
    req(0, 1'b0, 8'hF, 32'h80000000, 64'd0,    64'd0,         1'b1);

    // B: wait-state latency, then reset in the middle of a write
    req(1, 1'b1, 8'hF, 32'h8, 64'hCAFEF00D, 64'd0,        1'b0);
    req(1, 1'b0, 8'hF, 32'h8, 64'd0,        64'hCAFEF00D, 1'b0);
    cs[1] = 1'b1; we[1] = 1'b1; be[1] = 8'hF; addr[1] = 32'h8; wdata[1] = 64'h12345678;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n_b = 1'b0;
    cs[1] = 1'b0;
    #1;
    chk("midreset_ready", 64'(ready[1]), 64'd0);
    chk("midreset_err", 64'(err[1]), 64'd0);
    chk("midreset_rdata", rd[1], 64'd0);
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    @(negedge clk);
    req(1, 1'b0, 8'hF, 32'h8, 64'd0, 64'hCAFEF00D, 1'b0);

    // C: 64-bit data, lane 7 only, out-of-range boundary
    req(2, 1'b1, 8'hFF, 32'h78, 64'h0123456789ABCDEF, 64'd0,                 1'b0);
    req(2, 1'b0, 8'hFF, 32'h78, 64'd0,                64'h0123456789ABCDEF,  1'b0);
    req(2, 1'b1, 8'h80, 32'h78, 64'hFFFFFFFFFFFFFFFF, 64'd0,                 1'b0);
    req(2, 1'b0, 8'hFF, 32'h7F, 64'd0,                64'hFF23456789ABCDEF,  1'b0);
    req(2, 1'b0, 8'hFF, 32'h80, 64'd0,                64'd0,                 1'b1);

    repeat (10) @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
